// File: rtl/rom_pixel_out_if.sv
// ---------------------------------------------------------------------------
// rom_pixel_out_if
// Bundles every signal of the pixel output stage except the clock and reset.
// The signals fall into four groups:
//   scanner side  : hs_in, vs_in, de_in, addr_in   (into the stage)
//   image ROM     : rom_addr (out), rom_data (in, RGB565)
//   video side    : hs, vs, de, rgb_r, rgb_g, rgb_b (out)
//   status        : err_clr (in), h_err, v_err, frame_cnt (out)
// Modports:
//   slave  - the pixel output stage itself
//   master - whatever drives the scanner/ROM side and consumes the video side
// ---------------------------------------------------------------------------
interface rom_pixel_out_if;
    logic        hs_in;
    logic        vs_in;
    logic        de_in;
    logic [16:0] addr_in;
    logic [16:0] rom_addr;
    logic [15:0] rom_data;
    logic        hs;
    logic        vs;
    logic        de;
    logic [7:0]  rgb_r;
    logic [7:0]  rgb_g;
    logic [7:0]  rgb_b;
    logic        err_clr;
    logic        h_err;
    logic        v_err;
    logic [15:0] frame_cnt;

    modport slave (
        input  hs_in, vs_in, de_in, addr_in, rom_data, err_clr,
        output rom_addr, hs, vs, de, rgb_r, rgb_g, rgb_b, h_err, v_err, frame_cnt
    );

    modport master (
        output hs_in, vs_in, de_in, addr_in, rom_data, err_clr,
        input  rom_addr, hs, vs, de, rgb_r, rgb_g, rgb_b, h_err, v_err, frame_cnt
    );
endinterface

// File: rtl/rom_pixel_out.sv
// ---------------------------------------------------------------------------
// rom_pixel_out
// Downstream stage of the 1080P ROM scan generator. Registers the scanner
// address into a synchronous image ROM, expands the returned RGB565 word to
// RGB888 and delays hs/vs/de so they line up with the pixel data. Also checks
// the incoming timing (de pixels per line, active lines per frame) and counts
// frames.
// Ports:
//   clk  - pixel clock
//   rst  - synchronous reset, active-high
//   bus  - rom_pixel_out_if.slave: scanner inputs, ROM address/data, aligned
//          video outputs, sticky timing errors with clear, frame counter
// Pipeline latency from scanner input to video output is ROM_LATENCY + 2.
// ---------------------------------------------------------------------------
module rom_pixel_out #(
    parameter int          ROM_LATENCY  = 2,
    parameter int          EXP_H_ACTIVE = 1920,
    parameter int          EXP_V_ACTIVE = 1080,
    parameter logic [16:0] BLACK_ADDR   = 17'd6188
) (
    input  logic           clk,
    input  logic           rst,
    rom_pixel_out_if.slave bus
);

    // Address register + ROM latency + output register.
    localparam int          PIPE_LEN = ROM_LATENCY + 2;
    // Stage that is valid in the same cycle as rom_data; it feeds the
    // output register together with the ROM word.
    localparam int          OUT_TAP  = PIPE_LEN - 2;
    localparam logic [11:0] EXP_H    = 12'(EXP_H_ACTIVE);
    localparam logic [11:0] EXP_V    = 12'(EXP_V_ACTIVE);
    localparam logic [11:0] CNT_MAX  = 12'hFFF;

    // RGB565 -> RGB888 by replicating the top bits into the new LSBs, so
    // full-scale stays full-scale (1F -> FF) and zero stays zero.
    function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] d);
        return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
    endfunction

    logic [PIPE_LEN-1:0] hs_sr_q,  hs_sr_d;
    logic [PIPE_LEN-1:0] vs_sr_q,  vs_sr_d;
    logic [PIPE_LEN-1:0] de_sr_q,  de_sr_d;
    logic [PIPE_LEN-1:0] blk_sr_q, blk_sr_d;
    logic [16:0]         rom_addr_q, rom_addr_d;
    logic [23:0]         rgb_q, rgb_d;
    logic [11:0]         pix_cnt_q, pix_cnt_d;
    logic [11:0]         line_cnt_q, line_cnt_d;
    logic                de_prev_q, de_prev_d;
    logic                vs_prev_q, vs_prev_d;
    logic                first_q, first_d;
    logic                h_err_q, h_err_d;
    logic                v_err_q, v_err_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic                de_fall_s;
    logic                vs_rise_s;
    logic                h_set_s;
    logic                v_set_s;

    // Next-state logic: delay lines, colour path, timing checks, frame count.
    always_comb begin
        hs_sr_d     = {hs_sr_q[PIPE_LEN-2:0],  bus.hs_in};
        vs_sr_d     = {vs_sr_q[PIPE_LEN-2:0],  bus.vs_in};
        de_sr_d     = {de_sr_q[PIPE_LEN-2:0],  bus.de_in};
        blk_sr_d    = {blk_sr_q[PIPE_LEN-2:0], (bus.addr_in == BLACK_ADDR)};
        rom_addr_d  = bus.addr_in;

        // Blank outside the picture and on the scanner's black address.
        if (de_sr_q[OUT_TAP] && !blk_sr_q[OUT_TAP]) begin
            rgb_d = rgb565_to_rgb888(bus.rom_data);
        end else begin
            rgb_d = 24'h000000;
        end

        de_fall_s = de_prev_q & ~bus.de_in;
        vs_rise_s = ~vs_prev_q & bus.vs_in;
        de_prev_d = bus.de_in;
        vs_prev_d = bus.vs_in;

        // Pixel counter: counted value is compared before it is cleared.
        h_set_s = de_fall_s && (pix_cnt_q != EXP_H);
        if (de_fall_s) begin
            pix_cnt_d = 12'd0;
        end else if (bus.de_in && (pix_cnt_q != CNT_MAX)) begin
            pix_cnt_d = pix_cnt_q + 12'd1;
        end else begin
            pix_cnt_d = pix_cnt_q;
        end

        // Line counter: the clear on vs rising takes priority, so a de fall
        // coinciding with vs rising is not carried into the next frame.
        v_set_s = vs_rise_s && !first_q && (line_cnt_q != EXP_V);
        if (vs_rise_s) begin
            line_cnt_d = 12'd0;
        end else if (de_fall_s && (line_cnt_q != CNT_MAX)) begin
            line_cnt_d = line_cnt_q + 12'd1;
        end else begin
            line_cnt_d = line_cnt_q;
        end

        // The first frame after reset is usually partial; never judge it.
        if (vs_rise_s) begin
            first_d = 1'b0;
        end else begin
            first_d = first_q;
        end

        // Sticky errors: a new error beats a simultaneous clear.
        if (h_set_s) begin
            h_err_d = 1'b1;
        end else if (bus.err_clr) begin
            h_err_d = 1'b0;
        end else begin
            h_err_d = h_err_q;
        end

        if (v_set_s) begin
            v_err_d = 1'b1;
        end else if (bus.err_clr) begin
            v_err_d = 1'b0;
        end else begin
            v_err_d = v_err_q;
        end

        if (vs_rise_s) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // State registers with synchronous reset; first-frame flag re-arms.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_sr_q     <= '0;
            vs_sr_q     <= '0;
            de_sr_q     <= '0;
            blk_sr_q    <= '0;
            rom_addr_q  <= 17'd0;
            rgb_q       <= 24'h000000;
            pix_cnt_q   <= 12'd0;
            line_cnt_q  <= 12'd0;
            de_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            first_q     <= 1'b1;
            h_err_q     <= 1'b0;
            v_err_q     <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            hs_sr_q     <= hs_sr_d;
            vs_sr_q     <= vs_sr_d;
            de_sr_q     <= de_sr_d;
            blk_sr_q    <= blk_sr_d;
            rom_addr_q  <= rom_addr_d;
            rgb_q       <= rgb_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            de_prev_q   <= de_prev_d;
            vs_prev_q   <= vs_prev_d;
            first_q     <= first_d;
            h_err_q     <= h_err_d;
            v_err_q     <= v_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.hs        = hs_sr_q[PIPE_LEN-1];
    assign bus.vs        = vs_sr_q[PIPE_LEN-1];
    assign bus.de        = de_sr_q[PIPE_LEN-1];
    assign bus.rgb_r     = rgb_q[23:16];
    assign bus.rgb_g     = rgb_q[15:8];
    assign bus.rgb_b     = rgb_q[7:0];
    assign bus.h_err     = h_err_q;
    assign bus.v_err     = v_err_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_rom_pixel_out.sv
// Bench for rom_pixel_out: three instances (ROM latency 2, 1, 4) share one
// stimulus stream; each has its own ROM model, expected-output queue and
// monitor. Timing is shrunk to a 24x9 raster with a 16x6 active area.
module tb_rom_pixel_out;

    localparam int          H_ACT = 16;
    localparam int          H_TOT = 24;
    localparam int          V_ACT = 6;
    localparam int          V_TOT = 9;
    localparam logic [16:0] BLACK = 17'd6188;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
    } rec_t;

    logic        clk;
    logic        rst;
    logic        hs_in, vs_in, de_in, err_clr;
    logic [16:0] addr_in;

    int checks = 0;
    int errors = 0;

    rec_t        out_rec   [3];
    logic [16:0] out_addr  [3];
    logic        out_herr  [3];
    logic        out_verr  [3];
    logic [15:0] out_frame [3];

    // Reference model state (timing checker and frame counter)
    bit          mdl_valid = 1'b0;
    logic [16:0] m_addr;
    bit          m_herr, m_verr, m_first, m_pde, m_pvs;
    int          m_run, m_lines, m_frame;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    endfunction

    // Image ROM contents: fixed colours at 5..8, a hash elsewhere.
    function automatic logic [15:0] rom_word(input logic [16:0] a);
        case (a)
            17'd5:   return 16'hF800;
            17'd6:   return 16'h07E0;
            17'd7:   return 16'h001F;
            17'd8:   return 16'h8410;
            default: return (a[15:0] * 16'h9E37) ^ {a[16:9], a[7:0]};
        endcase
    endfunction

    function automatic logic [23:0] expand(input logic [15:0] w);
        int r5, g6, b5, r8, g8, b8;
        r5 = int'(w[15:11]);
        g6 = int'(w[10:5]);
        b5 = int'(w[4:0]);
        r8 = (r5 << 3) | (r5 >> 2);
        g8 = (g6 << 2) | (g6 >> 4);
        b8 = (b5 << 3) | (b5 >> 2);
        return {r8[7:0], g8[7:0], b8[7:0]};
    endfunction

    task automatic check(input string name, input int lat, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s lat=%0d t=%0t got=%h exp=%h", name, lat, $time, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lat
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        localparam int PL  = LAT + 2;

        rom_pixel_out_if bus ();

        rom_pixel_out #(
            .ROM_LATENCY  (LAT),
            .EXP_H_ACTIVE (H_ACT),
            .EXP_V_ACTIVE (V_ACT),
            .BLACK_ADDR   (BLACK)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );

        assign bus.hs_in   = hs_in;
        assign bus.vs_in   = vs_in;
        assign bus.de_in   = de_in;
        assign bus.addr_in = addr_in;
        assign bus.err_clr = err_clr;

        // Synchronous ROM model with LAT register stages
        logic [16:0] pipe [LAT];
        always @(posedge clk) begin
            pipe[0] <= bus.rom_addr;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign bus.rom_data = rom_word(pipe[LAT-1]);

        assign out_rec[g]   = {bus.hs, bus.vs, bus.de, bus.rgb_r, bus.rgb_g, bus.rgb_b};
        assign out_addr[g]  = bus.rom_addr;
        assign out_herr[g]  = bus.h_err;
        assign out_verr[g]  = bus.v_err;
        assign out_frame[g] = bus.frame_cnt;

        rec_t q [$];

        // Scoreboard push: expected output for the input sampled at this edge
        always @(posedge clk) begin
            rec_t e;
            if (rst) begin
                q.delete();
                repeat (PL) q.push_back('0);
            end else begin
                e.hs  = hs_in;
                e.vs  = vs_in;
                e.de  = de_in;
                e.rgb = (de_in && addr_in != BLACK) ? expand(rom_word(addr_in)) : 24'h0;
                q.push_back(e);
            end
        end

        // Monitor: outputs presented every cycle, compared away from the edge
        always @(negedge clk) begin
            rec_t e;
            if (q.size() >= PL) begin
                e = q.pop_front();
                check("video", LAT, 32'(out_rec[g]), 32'(e));
            end
            if (mdl_valid) begin
                check("rom_addr", LAT, 32'(out_addr[g]), 32'(m_addr));
                check("h_err", LAT, 32'(out_herr[g]), 32'(m_herr));
                check("v_err", LAT, 32'(out_verr[g]), 32'(m_verr));
                check("frame_cnt", LAT, 32'(out_frame[g]), 32'(m_frame));
            end
        end
    end

    // Behavioural timing checker: run lengths of de, lines between vs rises
    always @(posedge clk) begin
        bit fall, rise, hset, vset;
        if (rst) begin
            mdl_valid = 1'b1;
            m_addr = 17'd0; m_herr = 1'b0; m_verr = 1'b0; m_first = 1'b1;
            m_run = 0; m_lines = 0; m_frame = 0; m_pde = 1'b0; m_pvs = 1'b0;
        end else begin
            m_addr = addr_in;
            fall = m_pde && !de_in;
            rise = !m_pvs && vs_in;
            hset = fall && (m_run != H_ACT);
            vset = rise && !m_first && (m_lines != V_ACT);
            if (fall) begin
                m_lines++;
                m_run = 0;
            end else if (de_in) begin
                m_run++;
            end
            if (rise) begin
                m_first = 1'b0;
                m_lines = 0;
                m_frame = (m_frame + 1) % 65536;
            end
            if (hset) m_herr = 1'b1;
            else if (err_clr) m_herr = 1'b0;
            if (vset) m_verr = 1'b1;
            else if (err_clr) m_verr = 1'b0;
            m_pde = de_in;
            m_pvs = vs_in;
        end
    end

    task automatic drive(input logic h, input logic v, input logic d, input logic [16:0] a,
                         input logic c, input logic r);
        hs_in = h; vs_in = v; de_in = d; addr_in = a; err_clr = c; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_errs(input int exp_h, input int exp_v);
        for (int g = 0; g < 3; g++) begin
            check("h_err_dir", lat_of(g), 32'(out_herr[g]), 32'(exp_h));
            check("v_err_dir", lat_of(g), 32'(out_verr[g]), 32'(exp_v));
        end
    endtask

    // One raster frame; optional short line, short frame, clear, mid-frame reset
    task automatic gen_frame(input int n_act, input int bad_line, input int bad_len,
                             input bit clr_at_fall, input int rst_line);
        for (int v = 0; v < V_TOT; v++) begin
            for (int h = 0; h < H_TOT; h++) begin
                int len;
                logic d, r;
                logic [16:0] a;
                len = (v == bad_line) ? bad_len : H_ACT;
                d = (v < n_act) && (h < len);
                a = BLACK;
                if (d) a = ($urandom_range(0, 15) == 0) ? BLACK : 17'($urandom_range(0, 131071));
                r = (v == rst_line) && (h == H_TOT - 1);
                drive((h >= H_ACT + 2) && (h < H_ACT + 5), (v >= V_ACT + 1) && (v < V_ACT + 3), d, a,
                      clr_at_fall && (v == bad_line) && (h == len), r);
                if (r) begin
                    for (int g = 0; g < 3; g++) begin
                        check("rst_video", lat_of(g), 32'(out_rec[g]), 32'd0);
                        check("rst_addr", lat_of(g), 32'(out_addr[g]), 32'd0);
                        check("rst_frame", lat_of(g), 32'(out_frame[g]), 32'd0);
                    end
                    check_errs(0, 0);
                end
            end
        end
    endtask

    rec_t        dir_exp [6];
    logic [16:0] dir_addr [6];
    logic        dir_de [6];

    initial begin
        dir_addr = '{17'd5, 17'd6, 17'd7, 17'd8, BLACK, 17'd5};
        dir_de   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        dir_exp  = '{{3'b001, 24'hFF0000}, {3'b001, 24'h00FF00}, {3'b001, 24'h0000FF},
                     {3'b001, 24'h848284}, {3'b001, 24'h000000}, {3'b000, 24'h000000}};

        repeat (3) drive(1'b0, 1'b0, 1'b0, 17'd0, 1'b0, 1'b1);
        for (int g = 0; g < 3; g++) begin
            check("reset_video", lat_of(g), 32'(out_rec[g]), 32'd0);
            check("reset_frame", lat_of(g), 32'(out_frame[g]), 32'd0);
        end
        check_errs(0, 0);

        // Directed colour vectors; output appears at edge index k = L-1 + j
        for (int k = 0; k < 11; k++) begin
            if (k < 6) drive(1'b0, 1'b0, dir_de[k], dir_addr[k], 1'b0, 1'b0);
            else       drive(1'b0, 1'b0, 1'b0, 17'd0, 1'b0, 1'b0);
            for (int g = 0; g < 3; g++) begin
                int j;
                j = k - (lat_of(g) + 1);
                if (k < 6) check("dir_rom_addr", lat_of(g), 32'(out_addr[g]), 32'(dir_addr[k]));
                if (j >= 0 && j < 6) check("dir_video", lat_of(g), 32'(out_rec[g]), 32'(dir_exp[j]));
            end
        end

        // Random phase
        for (int i = 0; i < 300; i++) begin
            logic [16:0] a;
            a = ($urandom_range(0, 7) == 0) ? BLACK : 17'($urandom_range(0, 131071));
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                  ($urandom_range(0, 15) == 0), 1'b0);
        end

        repeat (2) drive(1'b0, 1'b0, 1'b0, 17'd0, 1'b0, 1'b1);

        repeat (3) gen_frame(V_ACT, -1, 0, 1'b0, -1);
        for (int g = 0; g < 3; g++) check("frame_cnt_3", lat_of(g), 32'(out_frame[g]), 32'd3);
        check_errs(0, 0);

        gen_frame(V_ACT, 2, H_ACT - 1, 1'b0, -1);
        check_errs(1, 0);
        drive(1'b0, 1'b0, 1'b0, BLACK, 1'b1, 1'b0);
        check_errs(0, 0);

        gen_frame(V_ACT, 0, H_ACT - 1, 1'b1, -1);
        check_errs(1, 0);
        drive(1'b0, 1'b0, 1'b0, BLACK, 1'b1, 1'b0);

        gen_frame(V_ACT, -1, 0, 1'b0, -1);
        check_errs(0, 0);
        gen_frame(V_ACT - 1, -1, 0, 1'b0, -1);
        check_errs(0, 1);
        drive(1'b0, 1'b0, 1'b0, BLACK, 1'b1, 1'b0);
        check_errs(0, 0);

        gen_frame(V_ACT, -1, 0, 1'b0, 2);
        check_errs(0, 0);
        gen_frame(V_ACT, -1, 0, 1'b0, -1);
        check_errs(0, 0);
        for (int g = 0; g < 3; g++) check("frame_cnt_rst", lat_of(g), 32'(out_frame[g]), 32'd2);

        repeat (8) drive(1'b0, 1'b0, 1'b0, 17'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
